pipe_ctrl: RTL and testbench

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_pkg.sv | 24 ++
 rtl/pipe_cnt.sv | 37 +++
 rtl/pipe_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_pipe_ctrl.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared state encoding, buffer indices and helpers for pipe_ctrl
package pipe_pkg;

    // Controller states; the encoding is visible on state_o
    typedef enum logic [2:0] {
        RUN   = 3'd0,
        DRAIN = 3'd1,
        PUSH  = 3'd2,
        JUMP  = 3'd3,
        HALT  = 3'd4
    } pipe_state_e;

    // Bit positions of the pipeline buffers in buf_en / buf_flush
    localparam int IFID  = 0;
    localparam int IDEX  = 1;
    localparam int EXMEM = 2;
    localparam int MEMWB = 3;

    // A phase of N cycles counts down from N-1 to 0
    function automatic logic [3:0] cyc_load(input int cyc);
        return 4'(cyc - 1);
    endfunction

endpackage

// File: rtl/pipe_cnt.sv
// rtl/pipe_cnt.sv - loadable 4-bit saturating down-counter with zero flag
module pipe_cnt (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [3:0] load_val,
    input  logic       dec,
    output logic [3:0] count,
    output logic       zero
);

    logic [3:0] cnt_q;
    logic [3:0] cnt_d;

    // Load wins over decrement; decrement stops at zero instead of wrapping
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != 4'd0)) begin
            cnt_d = cnt_q - 4'd1;
        end
    end

    // Counter register, cleared by reset
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= 4'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign count = cnt_q;
    assign zero  = (cnt_q == 4'd0);

endmodule

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - pipeline stall/flush/interrupt controller (interrupt path under PIPE_INT_EN)
module pipe_ctrl
    import pipe_pkg::*;
#(
    parameter int DRAIN_CYC = 3,
    parameter int PUSH_CYC  = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       mem_busy,
    input  logic       load_use,
    input  logic       branch_taken,
    input  logic       int_req,
    input  logic       halt,
    output logic [3:0] buf_en,
    output logic [3:0] buf_flush,
    output logic       pc_en,
    output logic       int_push,
    output logic       int_ack,
    output logic [2:0] state_o
);

    pipe_state_e state_q;
    pipe_state_e state_d;

    // Interrupt request as seen by the controller; constant low when interrupts are built out
    logic int_live;

`ifdef PIPE_INT_EN
    localparam logic [3:0] DRAIN_LD = cyc_load(DRAIN_CYC);
    localparam logic [3:0] PUSH_LD  = cyc_load(PUSH_CYC);

    logic       cnt_load;
    logic [3:0] cnt_load_val;
    logic       cnt_dec;
    logic       cnt_zero;
    logic [3:0] unused_cnt_value;

    assign int_live = int_req;

    pipe_cnt u_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .dec      (cnt_dec),
        .count    (unused_cnt_value),
        .zero     (cnt_zero)
    );
`else
    logic unused_int_cfg;

    assign int_live       = 1'b0;
    assign unused_int_cfg = ^{int_req, 4'(DRAIN_CYC), 4'(PUSH_CYC)};
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and phase counter control; mem_busy freezes everything except HALT
    always_comb begin
        state_d = state_q;
`ifdef PIPE_INT_EN
        cnt_load     = 1'b0;
        cnt_load_val = 4'd0;
        cnt_dec      = 1'b0;
`endif
        if (state_q == HALT) begin
`ifdef PIPE_INT_EN
            if (int_req) begin
                state_d      = DRAIN;
                cnt_load     = 1'b1;
                cnt_load_val = DRAIN_LD;
            end
`endif
        end else if (!mem_busy) begin
            case (state_q)
                RUN: begin
                    if (!branch_taken) begin
`ifdef PIPE_INT_EN
                        if (int_req) begin
                            state_d      = DRAIN;
                            cnt_load     = 1'b1;
                            cnt_load_val = DRAIN_LD;
                        end else
`endif
                        if (!load_use && halt) begin
                            state_d = HALT;
                        end
                    end
                end
`ifdef PIPE_INT_EN
                DRAIN: begin
                    if (cnt_zero) begin
                        state_d      = PUSH;
                        cnt_load     = 1'b1;
                        cnt_load_val = PUSH_LD;
                    end else begin
                        cnt_dec = 1'b1;
                    end
                end
                PUSH: begin
                    if (cnt_zero) begin
                        state_d = JUMP;
                    end else begin
                        cnt_dec = 1'b1;
                    end
                end
                JUMP: begin
                    state_d = RUN;
                end
`endif
                default: begin
                    state_d = RUN;
                end
            endcase
        end
    end

    // Output decode from state and live inputs; reset forces a full flush
    always_comb begin
        buf_en    = 4'b0000;
        buf_flush = 4'b0000;
        pc_en     = 1'b0;
        int_push  = 1'b0;
        int_ack   = 1'b0;
        if (rst) begin
            buf_flush = 4'b1111;
        end else if (!(mem_busy && (state_q != HALT))) begin
            case (state_q)
                RUN: begin
                    if (branch_taken) begin
                        buf_en          = 4'b1111;
                        buf_flush[IFID] = 1'b1;
                        buf_flush[IDEX] = 1'b1;
                        pc_en           = 1'b1;
                    end else if (load_use && !int_live) begin
                        // Hold IF/ID and PC, inject a bubble into ID/EX
                        buf_en[EXMEM]   = 1'b1;
                        buf_en[MEMWB]   = 1'b1;
                        buf_flush[IDEX] = 1'b1;
                    end else begin
                        buf_en = 4'b1111;
                        pc_en  = 1'b1;
                    end
                end
                HALT: begin
                    buf_en[IDEX]    = 1'b1;
                    buf_en[EXMEM]   = 1'b1;
                    buf_en[MEMWB]   = 1'b1;
                    buf_flush[IFID] = 1'b1;
                end
`ifdef PIPE_INT_EN
                DRAIN: begin
                    // Let in-flight instructions retire while feeding bubbles at IF/ID
                    buf_en[IDEX]    = 1'b1;
                    buf_en[EXMEM]   = 1'b1;
                    buf_en[MEMWB]   = 1'b1;
                    buf_flush[IFID] = 1'b1;
                    buf_flush[IDEX] = branch_taken;
                end
                PUSH: begin
                    int_push        = 1'b1;
                    buf_en[EXMEM]   = 1'b1;
                    buf_en[MEMWB]   = 1'b1;
                    buf_flush[IFID] = 1'b1;
                    buf_flush[IDEX] = 1'b1;
                end
                JUMP: begin
                    int_ack         = 1'b1;
                    pc_en           = 1'b1;
                    buf_en          = 4'b1111;
                    buf_flush[IFID] = 1'b1;
                    buf_flush[IDEX] = 1'b1;
                end
`endif
                default: begin
                    buf_en = 4'b0000;
                end
            endcase
        end
    end

    assign state_o = state_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - randomized and directed self-checking bench for pipe_ctrl
module tb_pipe_ctrl;

    localparam int DRAIN_CYC = 3;
    localparam int PUSH_CYC  = 2;
`ifdef PIPE_INT_EN
    localparam bit INT_EN = 1'b1;
`else
    localparam bit INT_EN = 1'b0;
`endif

    localparam int M_RUN   = 0;
    localparam int M_DRAIN = 1;
    localparam int M_PUSH  = 2;
    localparam int M_JUMP  = 3;
    localparam int M_HALT  = 4;

    logic       clk;
    logic       rst;
    logic       mem_busy;
    logic       load_use;
    logic       branch_taken;
    logic       int_req;
    logic       halt;
    logic [3:0] buf_en;
    logic [3:0] buf_flush;
    logic       pc_en;
    logic       int_push;
    logic       int_ack;
    logic [2:0] state_o;

    int n_checks = 0;
    int n_fail   = 0;

    int m_st  = M_RUN;
    int m_rem = 0;

    logic [2:0] obs_state;
    logic       obs_ack;

    pipe_ctrl #(
        .DRAIN_CYC (DRAIN_CYC),
        .PUSH_CYC  (PUSH_CYC)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .mem_busy     (mem_busy),
        .load_use     (load_use),
        .branch_taken (branch_taken),
        .int_req      (int_req),
        .halt         (halt),
        .buf_en       (buf_en),
        .buf_flush    (buf_flush),
        .pc_en        (pc_en),
        .int_push     (int_push),
        .int_ack      (int_ack),
        .state_o      (state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Expected outputs for the current cycle from the phase model and live inputs
    task automatic model_expect(output logic [3:0] en, output logic [3:0] fl,
                                output logic pc, output logic push, output logic ack);
        en = 4'h0; fl = 4'h0; pc = 1'b0; push = 1'b0; ack = 1'b0;
        if (rst) begin
            fl = 4'hF;
        end else if (mem_busy && m_st != M_HALT) begin
            en = 4'h0;
        end else begin
            case (m_st)
                M_RUN: begin
                    if (branch_taken)                 begin en = 4'hF; fl = 4'h3; pc = 1'b1; end
                    else if (INT_EN && int_req)       begin en = 4'hF; pc = 1'b1; end
                    else if (load_use)                begin en = 4'hC; fl = 4'h2; end
                    else                              begin en = 4'hF; pc = 1'b1; end
                end
                M_DRAIN: begin en = 4'hE; fl = branch_taken ? 4'h3 : 4'h1; end
                M_PUSH:  begin en = 4'hC; fl = 4'h3; push = 1'b1; end
                M_JUMP:  begin en = 4'hF; fl = 4'h3; pc = 1'b1; ack = 1'b1; end
                default: begin en = 4'hE; fl = 4'h1; end
            endcase
        end
    endtask

    // Advance the phase model by one clock: each phase lasts a fixed number of unstalled cycles
    task automatic model_step();
        if (rst) begin
            m_st = M_RUN; m_rem = 0;
        end else if (m_st == M_HALT) begin
            if (INT_EN && int_req) begin m_st = M_DRAIN; m_rem = DRAIN_CYC; end
        end else if (!mem_busy) begin
            case (m_st)
                M_RUN: begin
                    if (branch_taken)           m_st = M_RUN;
                    else if (INT_EN && int_req) begin m_st = M_DRAIN; m_rem = DRAIN_CYC; end
                    else if (load_use)          m_st = M_RUN;
                    else if (halt)              m_st = M_HALT;
                end
                M_DRAIN: begin
                    m_rem--;
                    if (m_rem == 0) begin m_st = M_PUSH; m_rem = PUSH_CYC; end
                end
                M_PUSH: begin
                    m_rem--;
                    if (m_rem == 0) m_st = M_JUMP;
                end
                default: m_st = M_RUN;
            endcase
        end
    endtask

    task automatic cycle(input bit r, input bit mb, input bit lu, input bit bt, input bit ir, input bit h);
        logic [3:0] e_en, e_fl;
        logic       e_pc, e_push, e_ack;
        @(posedge clk);
        #1;
        rst = r; mem_busy = mb; load_use = lu; branch_taken = bt; int_req = ir; halt = h;
        @(negedge clk);
        model_expect(e_en, e_fl, e_pc, e_push, e_ack);
        check_eq("buf_en",    {4'h0, buf_en},    {4'h0, e_en});
        check_eq("buf_flush", {4'h0, buf_flush}, {4'h0, e_fl});
        check_eq("pc_en",     {7'h0, pc_en},     {7'h0, e_pc});
        check_eq("int_push",  {7'h0, int_push},  {7'h0, e_push});
        check_eq("int_ack",   {7'h0, int_ack},   {7'h0, e_ack});
        check_eq("state_o",   {5'h0, state_o},   8'(m_st));
        obs_state = state_o;
        obs_ack   = int_ack;
        model_step();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        int seq_exp [7] = '{1, 1, 1, 2, 2, 3, 0};
        int ack_at;
        int ack_cnt;

        rst = 1'b1; mem_busy = 1'b0; load_use = 1'b0;
        branch_taken = 1'b0; int_req = 1'b0; halt = 1'b0;
        @(posedge clk);
        m_st = M_RUN; m_rem = 0;

        // Reset held two cycles, then normal run immediately
        cycle(1, 0, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0);

        // Branch beats load-use: no bubble
        cycle(0, 0, 1, 1, 0, 0);
        cycle(0, 0, 1, 0, 0, 0);
        idle(1);

`ifdef PIPE_INT_EN
        // Full interrupt sequence with default phase lengths
        cycle(0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 7; i++) begin
            idle(1);
            check_eq($sformatf("int_seq%0d", i), {5'h0, obs_state}, 8'(seq_exp[i]));
        end

        // Stall in DRAIN with the counter at 1, then PUSH two cycles after release
        cycle(0, 0, 0, 0, 1, 0);
        idle(1);
        for (int i = 0; i < 4; i++) cycle(0, 1, 0, 0, 0, 0);
        idle(1);
        check_eq("stall_rel0", {5'h0, obs_state}, 8'(M_DRAIN));
        idle(1);
        check_eq("stall_rel1", {5'h0, obs_state}, 8'(M_DRAIN));
        idle(1);
        check_eq("stall_rel2", {5'h0, obs_state}, 8'(M_PUSH));
        idle(3);

        // Halt, interrupt after five cycles, ack six cycles later
        cycle(0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 5; i++) cycle(0, 1, 0, 0, 0, 0);
        check_eq("halt_hold", {5'h0, obs_state}, 8'(M_HALT));
        cycle(0, 0, 0, 0, 1, 0);
        ack_at = 0;
        for (int i = 1; i <= 6; i++) begin
            idle(1);
            if (obs_ack && ack_at == 0) ack_at = i;
        end
        check_eq("halt_ack_at", 8'(ack_at), 8'd6);
        idle(1);

        // Reset during PUSH aborts the sequence without an ack
        cycle(0, 0, 0, 0, 1, 0);
        idle(4);
        check_eq("abort_in_push", {5'h0, obs_state}, 8'(M_PUSH));
        cycle(1, 0, 0, 0, 0, 0);
        ack_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            idle(1);
            if (obs_ack) ack_cnt++;
        end
        check_eq("abort_no_ack", 8'(ack_cnt), 8'd0);
        check_eq("abort_run", {5'h0, obs_state}, 8'(M_RUN));
`else
        // Interrupts built out: int_req never moves the state
        for (int i = 0; i < 5; i++) begin
            cycle(0, 0, 0, 0, 1, 0);
            check_eq($sformatf("no_int%0d", i), {5'h0, obs_state}, 8'(M_RUN));
        end
        cycle(0, 0, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 1, 0);
        check_eq("no_int_halt", {5'h0, obs_state}, 8'(M_HALT));
        cycle(0, 0, 0, 0, 1, 0);
        check_eq("no_int_halt_stay", {5'h0, obs_state}, 8'(M_HALT));
        cycle(1, 0, 0, 0, 0, 0);
        idle(1);
`endif

        // Randomized traffic against the phase model
        for (int i = 0; i < 2000; i++) begin
            cycle(($urandom_range(0, 63) == 0),
                  ($urandom_range(0, 6) == 0),
                  ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 4) == 0),
                  ($urandom_range(0, 7) == 0),
                  ($urandom_range(0, 11) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
